// File: rtl/seg7_multi_ctrl.sv
// Multi-digit seven-segment controller on a zero-wait Avalon-MM slave.
// Registered segment outputs with hex decode, per-digit enable, blink and raw mode.
module seg7_multi_ctrl #(
    parameter int NUM_DIGITS     = 6,
    parameter int BLINK_DIV      = 25000000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [3:0]              address,
    input  logic                    chipselect,
    input  logic                    write_n,
    input  logic [31:0]             writedata,
    output logic [31:0]             readdata,
    output logic [NUM_DIGITS*7-1:0] out_port
);

    localparam int             CW       = $clog2(BLINK_DIV);
    localparam logic [CW-1:0]  CNT_LAST = CW'(BLINK_DIV - 1);
    localparam logic [6:0]     IMG_ZERO = SEG_ACTIVE_LOW ? 7'h40 : 7'h3F;

    logic [2:0]              ctrl_q;
    logic [4*NUM_DIGITS-1:0] value_q;
    logic [NUM_DIGITS-1:0]   digit_en_q;
    logic [NUM_DIGITS-1:0]   blink_mask_q;
    logic [6:0]              raw_q [NUM_DIGITS];
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    phase_q, phase_d;
    logic [7*NUM_DIGITS-1:0] out_q, out_d;
    logic [6:0]              img [NUM_DIGITS];
    logic                    wr_en;

    assign wr_en    = chipselect && !write_n;
    assign out_port = out_q;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    // Blink divider follows the pre-edge CTRL, so a terminal-count toggle wins over a same-edge clear.
    always_comb begin
        cnt_d   = '0;
        phase_d = 1'b0;
        if (ctrl_q[1]) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                phase_d = !phase_q;
            end else begin
                cnt_d   = cnt_q + 1'b1;
                phase_d = phase_q;
            end
        end
    end

    always_comb begin
        out_d = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (ctrl_q[2] || !digit_en_q[i] || (ctrl_q[1] && blink_mask_q[i] && phase_q))
                img[i] = 7'h00;
            else if (ctrl_q[0])
                img[i] = hex7(value_q[4*i +: 4]);
            else
                img[i] = raw_q[i];
            out_d[7*i +: 7] = SEG_ACTIVE_LOW ? ~img[i] : img[i];
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            4'd0:    readdata = 32'(ctrl_q);
            4'd1:    readdata = 32'(value_q);
            4'd2:    readdata = 32'(digit_en_q);
            4'd3:    readdata = 32'(blink_mask_q);
            4'd4:    readdata = 32'(phase_q);
            default: readdata = '0;
        endcase
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (address == 4'(8 + i)) readdata = 32'(raw_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ctrl_q       <= 3'b001;
            value_q      <= '0;
            digit_en_q   <= '1;
            blink_mask_q <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) raw_q[i] <= '0;
            cnt_q        <= '0;
            phase_q      <= 1'b0;
            out_q        <= {NUM_DIGITS{IMG_ZERO}};
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            out_q   <= out_d;
            if (wr_en) begin
                case (address)
                    4'd0:    ctrl_q       <= writedata[2:0];
                    4'd1:    value_q      <= writedata[4*NUM_DIGITS-1:0];
                    4'd2:    digit_en_q   <= writedata[NUM_DIGITS-1:0];
                    4'd3:    blink_mask_q <= writedata[NUM_DIGITS-1:0];
                    default: ;
                endcase
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (address == 4'(8 + i)) raw_q[i] <= writedata[6:0];
                end
            end
        end
    end

endmodule
